id_stage_pipe: RTL and testbench

//  Registered RV64I/RV32I decode stage between IF and EX. Decodes one instruction per cycle,

---
 rtl/id_stage_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RV64I/RV32I decode stage with busy scoreboard and hazard stall
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        IF handshake; in_inst/in_pc carry the instruction and its PC
//   flush                    clears the output valid and every busy bit on the next edge
//   wb_ena/wb_addr           writeback completion, clears the busy bit of wb_addr
//   out_valid/out_ready      EX handshake
//   out_pc, out_imm          PC and sign-extended immediate of the decoded instruction
//   out_aluop, out_word      ALU operation and 32-bit word-op flag
//   out_rs1_*/out_rs2_*      source register reads
//   out_rd_*                 destination write (never enabled for x0)
//   out_op1_sel/out_op2_sel  operand muxes (pc / imm)
//   out_illegal              unsupported encoding; all enables forced low
module id_stage_pipe #(
    parameter int XLEN    = 64,
    parameter int NREG    = 32,
    parameter int ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    input  logic               flush,
    input  logic               wb_ena,
    input  logic [4:0]         wb_addr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_imm,
    output logic [ALUOP_W-1:0] out_aluop,
    output logic               out_word,
    output logic               out_rs1_ena,
    output logic [4:0]         out_rs1_addr,
    output logic               out_rs2_ena,
    output logic [4:0]         out_rs2_addr,
    output logic               out_rd_ena,
    output logic [4:0]         out_rd_addr,
    output logic               out_op1_sel,
    output logic               out_op2_sel,
    output logic               out_illegal
);

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    localparam logic IS_RV32 = (XLEN == 32);

    // funct3 -> ALU op; alt selects SUB/SRA (instruction bit 30)
    function automatic logic [3:0] alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_f3 = ALU_SLL;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            3'b100:  alu_f3 = ALU_XOR;
            3'b101:  alu_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    endfunction

    logic [6:0]        w_opcode;
    logic [2:0]        w_f3;
    logic [6:0]        w_f7;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [4:0]        w_rd;
    logic              w_shamt_hi;
    logic signed [11:0] w_i12;
    logic signed [11:0] w_s12;
    logic signed [12:0] w_b13;
    logic signed [31:0] w_u32;
    logic signed [20:0] w_j21;
    logic [XLEN-1:0]   w_imm_i;
    logic [XLEN-1:0]   w_imm_s;
    logic [XLEN-1:0]   w_imm_b;
    logic [XLEN-1:0]   w_imm_u;
    logic [XLEN-1:0]   w_imm_j;

    logic              w_illegal;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_use_rd;
    logic [3:0]        w_aluop;
    logic              w_word;
    logic              w_op1_sel;
    logic              w_op2_sel;
    logic [XLEN-1:0]   w_imm;

    logic              w_rs1_ena;
    logic              w_rs2_ena;
    logic              w_rd_ena;

    logic [NREG-1:0]   w_wb_mask;
    logic [NREG-1:0]   w_set_mask;
    logic [NREG-1:0]   w_busy_byp;
    logic              w_hazard;
    logic              w_accept;

    logic [NREG-1:0]   r_busy;
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [3:0]        r_aluop;
    logic              r_word;
    logic              r_rs1_ena;
    logic [4:0]        r_rs1_addr;
    logic              r_rs2_ena;
    logic [4:0]        r_rs2_addr;
    logic              r_rd_ena;
    logic [4:0]        r_rd_addr;
    logic              r_op1_sel;
    logic              r_op2_sel;
    logic              r_illegal;

    assign w_opcode = in_inst[6:0];
    assign w_f3     = in_inst[14:12];
    assign w_f7     = in_inst[31:25];
    assign w_rs1    = in_inst[19:15];
    assign w_rs2    = in_inst[24:20];
    assign w_rd     = in_inst[11:7];

    // shamt[5] only exists on RV64; on RV32 a set bit 25 is an illegal shift amount
    assign w_shamt_hi = IS_RV32 & in_inst[25];

    // signed intermediates so the size casts below sign-extend from inst[31]
    assign w_i12   = in_inst[31:20];
    assign w_s12   = {in_inst[31:25], in_inst[11:7]};
    assign w_b13   = {in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign w_u32   = {in_inst[31:12], 12'b0};
    assign w_j21   = {in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    assign w_imm_i = XLEN'(w_i12);
    assign w_imm_s = XLEN'(w_s12);
    assign w_imm_b = XLEN'(w_b13);
    assign w_imm_u = XLEN'(w_u32);
    assign w_imm_j = XLEN'(w_j21);

    always_comb begin
        w_illegal = 1'b0;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_aluop   = ALU_ADD;
        w_word    = 1'b0;
        w_op1_sel = 1'b0;
        w_op2_sel = 1'b0;
        w_imm     = '0;
        case (w_opcode)
            OPC_OP_IMM: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_op2_sel = 1'b1;
                w_imm     = w_imm_i;
                w_aluop   = alu_f3(w_f3, in_inst[30] & (w_f3 == 3'b101));
                if (w_f3 == 3'b001)
                    w_illegal = (in_inst[31:26] != 6'd0) | w_shamt_hi;
                else if (w_f3 == 3'b101)
                    w_illegal = ({in_inst[31], in_inst[29:26]} != 5'd0) | w_shamt_hi;
            end
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                w_aluop   = alu_f3(w_f3, in_inst[30]);
                w_illegal = !((w_f7 == 7'h00) ||
                              ((w_f7 == 7'h20) && ((w_f3 == 3'b000) || (w_f3 == 3'b101))));
            end
            OPC_OP_IMM_32: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_op2_sel = 1'b1;
                w_word    = 1'b1;
                w_imm     = w_imm_i;
                w_aluop   = alu_f3(w_f3, in_inst[30] & (w_f3 == 3'b101));
                case (w_f3)
                    3'b000:  w_illegal = IS_RV32;
                    3'b001:  w_illegal = IS_RV32 | (w_f7 != 7'h00);
                    3'b101:  w_illegal = IS_RV32 | !((w_f7 == 7'h00) || (w_f7 == 7'h20));
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_OP_32: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_use_rd  = 1'b1;
                w_word    = 1'b1;
                w_aluop   = alu_f3(w_f3, in_inst[30]);
                case (w_f3)
                    3'b000, 3'b101: w_illegal = IS_RV32 | !((w_f7 == 7'h00) || (w_f7 == 7'h20));
                    3'b001:         w_illegal = IS_RV32 | (w_f7 != 7'h00);
                    default:        w_illegal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_use_rd  = 1'b1;
                w_op2_sel = 1'b1;
                w_imm     = w_imm_u;
                w_aluop   = ALU_PASS;
            end
            OPC_AUIPC: begin
                w_use_rd  = 1'b1;
                w_op1_sel = 1'b1;
                w_op2_sel = 1'b1;
                w_imm     = w_imm_u;
            end
            OPC_JAL: begin
                w_use_rd  = 1'b1;
                w_op1_sel = 1'b1;
                w_op2_sel = 1'b1;
                w_imm     = w_imm_j;
            end
            OPC_JALR: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_op2_sel = 1'b1;
                w_imm     = w_imm_i;
            end
            OPC_BRANCH: begin
                // EX compares rs1/rs2: SUB for eq/ne, SLT for lt/ge, SLTU for ltu/geu
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_imm     = w_imm_b;
                case (w_f3[2:1])
                    2'b10:   w_aluop = ALU_SLT;
                    2'b11:   w_aluop = ALU_SLTU;
                    default: w_aluop = ALU_SUB;
                endcase
            end
            OPC_LOAD: begin
                w_use_rs1 = 1'b1;
                w_use_rd  = 1'b1;
                w_op2_sel = 1'b1;
                w_imm     = w_imm_i;
            end
            OPC_STORE: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_op2_sel = 1'b1;
                w_imm     = w_imm_s;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_rs1_ena = w_use_rs1 & ~w_illegal;
    assign w_rs2_ena = w_use_rs2 & ~w_illegal;
    assign w_rd_ena  = w_use_rd & ~w_illegal & (w_rd != 5'd0);

    always_comb begin
        w_wb_mask  = '0;
        w_set_mask = '0;
        if (wb_ena)
            w_wb_mask[wb_addr] = 1'b1;
        if (w_accept && w_rd_ena)
            w_set_mask[w_rd] = 1'b1;
    end

    // a writeback landing this cycle already frees its register for the hazard check
    assign w_busy_byp = r_busy & ~w_wb_mask;
    assign w_hazard   = (w_rs1_ena & w_busy_byp[w_rs1]) |
                        (w_rs2_ena & w_busy_byp[w_rs2]) |
                        (w_rd_ena  & w_busy_byp[w_rd]);
    assign in_ready   = rst & ~flush & ~w_hazard & (~r_valid | out_ready);
    assign w_accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_busy <= '0;
        else if (flush)
            r_busy <= '0;
        else
            r_busy <= (w_busy_byp | w_set_mask) & ~NREG'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_valid <= 1'b0;
        else if (flush)
            r_valid <= 1'b0;
        else if (w_accept)
            r_valid <= 1'b1;
        else if (out_ready)
            r_valid <= 1'b0;
    end

    // payload only moves on accept, so it holds under backpressure
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= '0;
            r_imm      <= '0;
            r_aluop    <= '0;
            r_word     <= 1'b0;
            r_rs1_ena  <= 1'b0;
            r_rs1_addr <= '0;
            r_rs2_ena  <= 1'b0;
            r_rs2_addr <= '0;
            r_rd_ena   <= 1'b0;
            r_rd_addr  <= '0;
            r_op1_sel  <= 1'b0;
            r_op2_sel  <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_pc       <= in_pc;
            r_imm      <= w_imm;
            r_aluop    <= w_aluop;
            r_word     <= w_word;
            r_rs1_ena  <= w_rs1_ena;
            r_rs1_addr <= w_rs1;
            r_rs2_ena  <= w_rs2_ena;
            r_rs2_addr <= w_rs2;
            r_rd_ena   <= w_rd_ena;
            r_rd_addr  <= w_rd;
            r_op1_sel  <= w_op1_sel;
            r_op2_sel  <= w_op2_sel;
            r_illegal  <= w_illegal;
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_imm      = r_imm;
    assign out_aluop    = ALUOP_W'(r_aluop);
    assign out_word     = r_word;
    assign out_rs1_ena  = r_rs1_ena;
    assign out_rs1_addr = r_rs1_addr;
    assign out_rs2_ena  = r_rs2_ena;
    assign out_rs2_addr = r_rs2_addr;
    assign out_rd_ena   = r_rd_ena;
    assign out_rd_addr  = r_rd_addr;
    assign out_op1_sel  = r_op1_sel;
    assign out_op2_sel  = r_op2_sel;
    assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed and randomized bench for id_stage_pipe against a reference model
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        flush;
    logic        wb_ena;
    logic [4:0]  wb_addr;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_imm;
    logic [3:0]  out_aluop;
    logic        out_word;
    logic        out_rs1_ena;
    logic [4:0]  out_rs1_addr;
    logic        out_rs2_ena;
    logic [4:0]  out_rs2_addr;
    logic        out_rd_ena;
    logic [4:0]  out_rd_addr;
    logic        out_op1_sel;
    logic        out_op2_sel;
    logic        out_illegal;

    logic        r32_in_ready;
    logic        o32_valid;
    logic [31:0] o32_pc;
    logic [31:0] o32_imm;
    logic [3:0]  o32_aluop;
    logic        o32_word;
    logic        o32_rs1_ena;
    logic [4:0]  o32_rs1_addr;
    logic        o32_rs2_ena;
    logic [4:0]  o32_rs2_addr;
    logic        o32_rd_ena;
    logic [4:0]  o32_rd_addr;
    logic        o32_op1_sel;
    logic        o32_op2_sel;
    logic        o32_illegal;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(64), .NREG(32), .ALUOP_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .wb_ena(wb_ena), .wb_addr(wb_addr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
        .out_aluop(out_aluop), .out_word(out_word),
        .out_rs1_ena(out_rs1_ena), .out_rs1_addr(out_rs1_addr),
        .out_rs2_ena(out_rs2_ena), .out_rs2_addr(out_rs2_addr),
        .out_rd_ena(out_rd_ena), .out_rd_addr(out_rd_addr),
        .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel), .out_illegal(out_illegal)
    );

    id_stage_pipe #(.XLEN(32), .NREG(32), .ALUOP_W(4)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r32_in_ready),
        .in_inst(in_inst), .in_pc(in_pc[31:0]), .flush(flush),
        .wb_ena(wb_ena), .wb_addr(wb_addr),
        .out_valid(o32_valid), .out_ready(out_ready), .out_pc(o32_pc), .out_imm(o32_imm),
        .out_aluop(o32_aluop), .out_word(o32_word),
        .out_rs1_ena(o32_rs1_ena), .out_rs1_addr(o32_rs1_addr),
        .out_rs2_ena(o32_rs2_ena), .out_rs2_addr(o32_rs2_addr),
        .out_rd_ena(o32_rd_ena), .out_rd_addr(o32_rd_addr),
        .out_op1_sel(o32_op1_sel), .out_op2_sel(o32_op2_sel), .out_illegal(o32_illegal)
    );

    typedef struct packed {
        logic        ill;
        logic        rs1e;
        logic        rs2e;
        logic        rde;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        word;
        logic        op1;
        logic        op2;
        logic [63:0] imm;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    // reference state: what EX should be seeing, and which registers have a write in flight
    bit          m_valid;
    exp_t        m_out;
    logic [63:0] m_pc;
    bit [31:0]   m_busy;
    logic        last_ready;

    int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sign-extend the low 'bits' bits of v arithmetically
    function automatic logic [63:0] sx(input logic [63:0] v, input int bits);
        logic [63:0] m;
        m = 64'd1 << (bits - 1);
        return (v ^ m) - m;
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] inst, input bit x32);
        exp_t e;
        int   f3;
        int   f7;
        bit   u1, u2, ud;
        e = '0;
        u1 = 0; u2 = 0; ud = 0;
        f3 = int'(inst[14:12]);
        f7 = int'(inst[31:25]);
        e.rs1 = inst[19:15];
        e.rs2 = inst[24:20];
        e.rd  = inst[11:7];
        case (inst[6:0])
            7'h13: begin
                u1 = 1; ud = 1; e.op2 = 1;
                e.imm = sx(64'(inst[31:20]), 12);
                e.alu = 4'(alu_tab[f3]);
                if (f3 == 1) e.ill = (inst[31:26] != 0) || (x32 && inst[25]);
                if (f3 == 5) begin
                    e.ill = !(inst[31:26] == 6'h00 || inst[31:26] == 6'h10) || (x32 && inst[25]);
                    if (inst[30]) e.alu = e.alu + 4'd1;
                end
            end
            7'h33: begin
                u1 = 1; u2 = 1; ud = 1;
                e.alu = 4'(alu_tab[f3]);
                if (f7 == 32) begin
                    if (f3 == 0 || f3 == 5) e.alu = e.alu + 4'd1;
                    else e.ill = 1;
                end else if (f7 != 0) e.ill = 1;
            end
            7'h1B: begin
                u1 = 1; ud = 1; e.op2 = 1; e.word = 1;
                e.imm = sx(64'(inst[31:20]), 12);
                e.alu = 4'(alu_tab[f3]);
                if (f3 == 1) e.ill = (f7 != 0);
                else if (f3 == 5) begin
                    e.ill = !(f7 == 0 || f7 == 32);
                    if (f7 == 32) e.alu = e.alu + 4'd1;
                end else if (f3 != 0) e.ill = 1;
                if (x32) e.ill = 1;
            end
            7'h3B: begin
                u1 = 1; u2 = 1; ud = 1; e.word = 1;
                e.alu = 4'(alu_tab[f3]);
                if (f3 == 0 || f3 == 5) begin
                    e.ill = !(f7 == 0 || f7 == 32);
                    if (f7 == 32) e.alu = e.alu + 4'd1;
                end else if (f3 == 1) e.ill = (f7 != 0);
                else e.ill = 1;
                if (x32) e.ill = 1;
            end
            7'h37: begin ud = 1; e.op2 = 1; e.alu = 4'd10; e.imm = sx(64'(inst[31:12]) << 12, 32); end
            7'h17: begin ud = 1; e.op1 = 1; e.op2 = 1; e.imm = sx(64'(inst[31:12]) << 12, 32); end
            7'h6F: begin
                ud = 1; e.op1 = 1; e.op2 = 1;
                e.imm = sx(64'(inst[31]) * 1048576 + 64'(inst[19:12]) * 4096 +
                           64'(inst[20]) * 2048 + 64'(inst[30:21]) * 2, 21);
            end
            7'h67: begin u1 = 1; ud = 1; e.op2 = 1; e.imm = sx(64'(inst[31:20]), 12); end
            7'h63: begin
                u1 = 1; u2 = 1;
                e.alu = (f3 >= 6) ? 4'd4 : (f3 >= 4) ? 4'd3 : 4'd1;
                e.imm = sx(64'(inst[31]) * 4096 + 64'(inst[7]) * 2048 +
                           64'(inst[30:25]) * 32 + 64'(inst[11:8]) * 2, 13);
            end
            7'h03: begin u1 = 1; ud = 1; e.op2 = 1; e.imm = sx(64'(inst[31:20]), 12); end
            7'h23: begin
                u1 = 1; u2 = 1; e.op2 = 1;
                e.imm = sx(64'(inst[31:25]) * 32 + 64'(inst[11:7]), 12);
            end
            default: e.ill = 1;
        endcase
        e.rs1e = u1 && !e.ill;
        e.rs2e = u2 && !e.ill;
        e.rde  = ud && !e.ill && (e.rd != 0);
        return e;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs[13] = '{7'h13, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63,
                                 7'h03, 7'h23, 7'h1B, 7'h3B, 7'h7F, 7'h0B};
        logic [6:0] f7;
        int sel;
        sel = int'($urandom_range(0, 2));
        f7 = (sel == 0) ? 7'h00 : (sel == 1) ? 7'h20 : 7'($urandom);
        return {f7, 5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)), 3'($urandom),
                5'($urandom_range(0, 5)), opcs[$urandom_range(0, 12)]};
    endfunction

    task automatic check_out(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk({tag, ".out_pc"}, out_pc, m_pc);
            chk({tag, ".out_illegal"}, 64'(out_illegal), 64'(m_out.ill));
            chk({tag, ".out_rs1_ena"}, 64'(out_rs1_ena), 64'(m_out.rs1e));
            chk({tag, ".out_rs2_ena"}, 64'(out_rs2_ena), 64'(m_out.rs2e));
            chk({tag, ".out_rd_ena"}, 64'(out_rd_ena), 64'(m_out.rde));
            if (!m_out.ill) begin
                chk({tag, ".out_imm"}, out_imm, m_out.imm);
                chk({tag, ".out_aluop"}, 64'(out_aluop), 64'(m_out.alu));
                chk({tag, ".out_word"}, 64'(out_word), 64'(m_out.word));
                chk({tag, ".out_rs1_addr"}, 64'(out_rs1_addr), 64'(m_out.rs1));
                chk({tag, ".out_rs2_addr"}, 64'(out_rs2_addr), 64'(m_out.rs2));
                chk({tag, ".out_rd_addr"}, 64'(out_rd_addr), 64'(m_out.rd));
                chk({tag, ".out_op1_sel"}, 64'(out_op1_sel), 64'(m_out.op1));
                chk({tag, ".out_op2_sel"}, 64'(out_op2_sel), 64'(m_out.op2));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".out_pc"}, out_pc, 64'd0);
        chk({tag, ".out_imm"}, out_imm, 64'd0);
        chk({tag, ".out_aluop"}, 64'(out_aluop), 64'd0);
        chk({tag, ".enables"}, 64'({out_rs1_ena, out_rs2_ena, out_rd_ena}), 64'd0);
        chk({tag, ".addrs"}, 64'({out_rs1_addr, out_rs2_addr, out_rd_addr}), 64'd0);
        chk({tag, ".misc"}, 64'({out_word, out_op1_sel, out_op2_sel, out_illegal}), 64'd0);
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_busy  = '0;
        m_out   = '0;
        m_pc    = '0;
    endtask

    // inputs are applied at a falling edge; check in_ready, clock once, check outputs
    task automatic step(input string tag);
        exp_t      d;
        bit [31:0] bb;
        bit        hz, er, acc;
        #1;
        d  = ref_decode(in_inst, 1'b0);
        bb = m_busy;
        if (wb_ena) bb[wb_addr] = 1'b0;
        hz = (d.rs1e && bb[d.rs1]) || (d.rs2e && bb[d.rs2]) || (d.rde && bb[d.rd]);
        er = rst && !flush && !hz && (!m_valid || out_ready);
        last_ready = in_ready;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(er));
        acc = in_valid && er;
        @(posedge clk);
        if (flush) begin
            m_valid = 0;
            m_busy  = '0;
        end else begin
            m_busy = bb;
            if (acc) begin
                m_valid = 1;
                m_out   = d;
                m_pc    = in_pc;
                if (d.rde) m_busy[d.rd] = 1'b1;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
        check_out(tag);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 64'h0;
        flush = 1'b0; wb_ena = 1'b0; wb_addr = 5'd0; out_ready = 1'b1;
        last_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("reset");

        // addi x1,x0,5 right after reset release
        rst = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h1000;
        step("s1");
        chk("s1.valid", 64'(out_valid), 64'd1);
        chk("s1.imm", out_imm, 64'd5);
        chk("s1.aluop", 64'(out_aluop), 64'd0);
        chk("s1.rd", 64'(out_rd_addr), 64'd1);
        chk("s1.rs1_ena", 64'(out_rs1_ena), 64'd1);
        chk("s1.op2_sel", 64'(out_op2_sel), 64'd1);

        // add x2,x1,x1 waits for x1, then goes on the writeback cycle
        in_inst = 32'h00108133; in_pc = 64'h1004;
        step("s2a");
        chk("s2.stall", 64'(last_ready), 64'd0);
        wb_ena = 1'b1; wb_addr = 5'd1;
        step("s2b");
        chk("s2.bypass", 64'(last_ready), 64'd1);
        chk("s2.rd", 64'(out_rd_addr), 64'd2);

        // sub x2,x1,x2 held under backpressure
        in_valid = 1'b0; wb_addr = 5'd2;
        step("s3drain");
        wb_ena = 1'b0; in_valid = 1'b1; in_inst = 32'h40208133; in_pc = 64'h1008;
        step("s3acc");
        chk("s3.aluop", 64'(out_aluop), 64'd1);
        out_ready = 1'b0; in_inst = 32'h00000013; in_pc = 64'h100C;
        for (int i = 0; i < 3; i++) begin
            step("s3hold");
            chk("s3.hold_valid", 64'(out_valid), 64'd1);
            chk("s3.hold_aluop", 64'(out_aluop), 64'd1);
            chk("s3.hold_ready", 64'(last_ready), 64'd0);
        end
        out_ready = 1'b1; wb_ena = 1'b1; wb_addr = 5'd2;
        step("s3rel");
        wb_ena = 1'b0;

        // fill busy[1..3], then flush
        in_inst = 32'h00100093; step("s4x1");
        in_inst = 32'h00100113; step("s4x2");
        in_inst = 32'h00100193; step("s4x3");
        flush = 1'b1; in_inst = 32'h002081B3;
        step("s4flush");
        chk("s4.flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0;
        step("s4after");
        chk("s4.busy_clear", 64'(last_ready), 64'd1);

        // illegal word leaves busy[3] alone
        in_inst = 32'hFFFFFFFF;
        step("s5ill");
        chk("s5.illegal", 64'(out_illegal), 64'd1);
        chk("s5.enables", 64'({out_rs1_ena, out_rs2_ena, out_rd_ena}), 64'd0);
        in_inst = 32'h00018233;
        step("s5busy");
        chk("s5.busy_kept", 64'(last_ready), 64'd0);

        // asynchronous reset in the middle of that stall
        #2 rst = 1'b0;
        #1 check_zero("s6rst");
        model_reset();
        @(negedge clk);
        rst = 1'b1; in_inst = 32'h00500093; in_pc = 64'h2000;
        step("s6s1");
        chk("s6.imm", out_imm, 64'd5);
        chk("s6.rd", 64'(out_rd_addr), 64'd1);

        // addiw: legal word op on RV64, illegal on RV32
        in_inst = 32'h0020009B; in_pc = 64'h2004; wb_ena = 1'b1; wb_addr = 5'd1;
        step("s5w");
        wb_ena = 1'b0;
        chk("s5w.word64", 64'(out_word), 64'd1);
        chk("s5w.valid32", 64'(o32_valid), 64'd1);
        chk("s5w.illegal32", 64'(o32_illegal), 64'd1);
        chk("s5w.enables32", 64'({o32_rs1_ena, o32_rs2_ena, o32_rd_ena}), 64'd0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_inst   = rand_inst();
            in_pc     = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            wb_ena    = $urandom_range(0, 1) == 1;
            wb_addr   = 5'($urandom_range(0, 5));
            flush     = ($urandom_range(0, 24) == 0);
            step("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
